// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle main FSM and its datapath.
//   i_Opcode   : opcode field of the instruction register (instr[6:0])
//   i_Zero     : ALU zero flag, combinational, current cycle
//   i_MemReady : memory finished the current read/write this cycle
//   o_PCen .. o_ALUop : datapath/memory control strobes and mux selects
//   o_State    : current FSM state encoding (debug)
//   o_Illegal  : one-cycle pulse on an unsupported opcode
// Modports: master = the control FSM, slave = the datapath side.
// Handshake: a memory request (o_MemRead/o_MemWrite) stays asserted and the
// FSM holds its state until the cycle in which i_MemReady is 1; that cycle
// completes the transfer and the FSM advances on the next clock edge.
interface mc_control_fsm_if #(
  parameter int OPW = 7,
  parameter int SW  = 4
);
  logic [OPW-1:0] i_Opcode;
  logic           i_Zero;
  logic           i_MemReady;
  logic           o_PCen;
  logic           o_IorD;
  logic [1:0]     o_PCsrc;
  logic           o_IRwrite;
  logic           o_MemRead;
  logic           o_MemWrite;
  logic           o_RegWrite;
  logic [1:0]     o_ResultSrc;
  logic [1:0]     o_ALUsrcA;
  logic [1:0]     o_ALUsrcB;
  logic [1:0]     o_ALUop;
  logic [SW-1:0]  o_State;
  logic           o_Illegal;

  modport master (
    input  i_Opcode, i_Zero, i_MemReady,
    output o_PCen, o_IorD, o_PCsrc, o_IRwrite, o_MemRead, o_MemWrite,
           o_RegWrite, o_ResultSrc, o_ALUsrcA, o_ALUsrcB, o_ALUop,
           o_State, o_Illegal
  );

  modport slave (
    output i_Opcode, i_Zero, i_MemReady,
    input  o_PCen, o_IorD, o_PCsrc, o_IRwrite, o_MemRead, o_MemWrite,
           o_RegWrite, o_ResultSrc, o_ALUsrcA, o_ALUsrcB, o_ALUop,
           o_State, o_Illegal
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle datapath.
// Sequences fetch, decode, execute, memory and writeback from the IR opcode.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous, active-high reset (state returns to IDLE)
//   bus     : mc_control_fsm_if.master -- opcode/zero/memory-ready in,
//             all datapath controls, debug state and illegal pulse out
// Moore machine: one registered state; outputs are a decode of the state,
// except PC/IR enables in FETCH (gated by i_MemReady) and PC enable in BEQ
// (taken from the live i_Zero flag).
module mc_control_fsm #(
  parameter int OPW = 7,
  parameter int SW  = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  mc_control_fsm_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXER   = 4'd7,
    S_EXEI   = 4'd8,
    S_ALUWB  = 4'd9,
    S_BEQ    = 4'd10,
    S_JAL    = 4'd11,
    S_ILL    = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_LW  = OPW'(7'b0000011);
  localparam logic [OPW-1:0] OP_SW  = OPW'(7'b0100011);
  localparam logic [OPW-1:0] OP_R   = OPW'(7'b0110011);
  localparam logic [OPW-1:0] OP_I   = OPW'(7'b0010011);
  localparam logic [OPW-1:0] OP_BEQ = OPW'(7'b1100011);
  localparam logic [OPW-1:0] OP_JAL = OPW'(7'b1101111);

  state_t state_q, state_d;

  logic       pcen, iord, irwrite, memread, memwrite, regwrite, illegal;
  logic [1:0] pcsrc, resultsrc, srca, srcb, aluop;

  // Next-state logic.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = bus.i_MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (bus.i_Opcode == OP_LW || bus.i_Opcode == OP_SW) state_d = S_MEMADR;
        else if (bus.i_Opcode == OP_R)   state_d = S_EXER;
        else if (bus.i_Opcode == OP_I)   state_d = S_EXEI;
        else if (bus.i_Opcode == OP_BEQ) state_d = S_BEQ;
        else if (bus.i_Opcode == OP_JAL) state_d = S_JAL;
        else                             state_d = S_ILL;
      end
      // Only lw/sw reach MEMADR; the IR still holds that opcode here.
      S_MEMADR: state_d = (bus.i_Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = bus.i_MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = bus.i_MemReady ? S_FETCH : S_MEMWR;
      S_EXER:   state_d = S_ALUWB;
      S_EXEI:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JAL:    state_d = S_FETCH;
      S_ILL:    state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Output decode; anything not set for a state stays 0.
  always_comb begin
    pcen      = 1'b0;
    iord      = 1'b0;
    pcsrc     = 2'b00;
    irwrite   = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 2'b00;
    srca      = 2'b00;
    srcb      = 2'b00;
    aluop     = 2'b00;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        srcb    = 2'b01;
        // PC+4 and the IR load only in the cycle the read completes.
        if (bus.i_MemReady) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
        end
      end
      S_DECODE: begin
        srca = 2'b10;
        srcb = 2'b10;
      end
      S_MEMADR: begin
        srca = 2'b01;
        srcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite  = 1'b1;
        resultsrc = 2'b01;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXER: begin
        srca  = 2'b01;
        aluop = 2'b10;
      end
      S_EXEI: begin
        srca  = 2'b01;
        srcb  = 2'b10;
        aluop = 2'b10;
      end
      S_ALUWB: regwrite = 1'b1;
      S_BEQ: begin
        srca  = 2'b01;
        aluop = 2'b01;
        pcsrc = 2'b01;
        pcen  = bus.i_Zero;
      end
      S_JAL: begin
        pcsrc     = 2'b01;
        pcen      = 1'b1;
        regwrite  = 1'b1;
        resultsrc = 2'b10;
      end
      S_ILL:   illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_PCen      = pcen;
  assign bus.o_IorD      = iord;
  assign bus.o_PCsrc     = pcsrc;
  assign bus.o_IRwrite   = irwrite;
  assign bus.o_MemRead   = memread;
  assign bus.o_MemWrite  = memwrite;
  assign bus.o_RegWrite  = regwrite;
  assign bus.o_ResultSrc = resultsrc;
  assign bus.o_ALUsrcA   = srca;
  assign bus.o_ALUsrcB   = srcb;
  assign bus.o_ALUop     = aluop;
  assign bus.o_State     = SW'(state_q);
  assign bus.o_Illegal   = illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: per-instruction trace generator builds the
// expected cycle-by-cycle control trace (with stimulus) into a queue; a
// driver replays the stimulus and compares every cycle's outputs.
module tb_mc_control_fsm;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_fsm_if #(.OPW(7), .SW(4)) bif ();

  mc_control_fsm #(.OPW(7), .SW(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bif.master)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW_ = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  typedef struct packed {
    logic [3:0] state;
    logic       pcen, iord;
    logic [1:0] pcsrc;
    logic       irwrite, memread, memwrite, regwrite;
    logic [1:0] resultsrc, srca, srcb, aluop;
    logic       illegal;
  } exp_t;

  typedef struct packed {
    logic       rst, ready, zero, chk;
    logic [6:0] op;
    exp_t       e;
  } cyc_t;

  localparam int W = $bits(cyc_t);
  logic [W-1:0] exp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc_no = 0;
  logic [6:0] cur_op = 7'd0;

  // One cycle of the trace: state given, all controls 0, don't-care
  // inputs randomised so the FSM is shown to ignore them.
  function automatic cyc_t c(input logic [3:0] st);
    cyc_t r;
    r = '0;
    r.e.state = st;
    r.op      = cur_op;
    r.ready   = 1'($urandom_range(0, 1));
    r.zero    = 1'($urandom_range(0, 1));
    r.chk     = 1'b1;
    return r;
  endfunction

  task automatic push(input cyc_t r);
    exp_q.push_back(r);
  endtask

  task automatic push_fetch(input int waits);
    cyc_t r;
    for (int i = 0; i <= waits; i++) begin
      r = c(4'd1);
      r.e.memread = 1'b1;
      r.e.srcb    = 2'b01;
      r.ready     = (i == waits);
      r.e.irwrite = (i == waits);
      r.e.pcen    = (i == waits);
      push(r);
    end
  endtask

  // Memory wait phase: waits cycles without ready, then one with ready.
  task automatic push_mem(input logic [3:0] st, input logic wr, input int waits);
    cyc_t r;
    for (int i = 0; i <= waits; i++) begin
      r = c(st);
      r.e.iord     = 1'b1;
      r.e.memread  = ~wr;
      r.e.memwrite = wr;
      r.ready      = (i == waits);
      push(r);
    end
  endtask

  // Expected trace of one whole instruction, starting in FETCH.
  task automatic gen_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic z);
    cyc_t r;
    cur_op = op;
    push_fetch(fw);
    r = c(4'd2); r.e.srca = 2'b10; r.e.srcb = 2'b10; push(r);
    if (op == LW || op == SW_) begin
      r = c(4'd3); r.e.srca = 2'b01; r.e.srcb = 2'b10; push(r);
      if (op == LW) begin
        push_mem(4'd4, 1'b0, mw);
        r = c(4'd5); r.e.regwrite = 1'b1; r.e.resultsrc = 2'b01; push(r);
      end else begin
        push_mem(4'd6, 1'b1, mw);
      end
    end else if (op == RT || op == IT) begin
      r = c(op == RT ? 4'd7 : 4'd8);
      r.e.srca  = 2'b01;
      r.e.srcb  = (op == RT) ? 2'b00 : 2'b10;
      r.e.aluop = 2'b10;
      push(r);
      r = c(4'd9); r.e.regwrite = 1'b1; push(r);
    end else if (op == BQ) begin
      r = c(4'd10);
      r.zero = z; r.e.srca = 2'b01; r.e.aluop = 2'b01;
      r.e.pcsrc = 2'b01; r.e.pcen = z;
      push(r);
    end else if (op == JL) begin
      r = c(4'd11);
      r.e.pcsrc = 2'b01; r.e.pcen = 1'b1;
      r.e.regwrite = 1'b1; r.e.resultsrc = 2'b10;
      push(r);
    end else begin
      r = c(4'd12); r.e.illegal = 1'b1; push(r);
    end
  endtask

  // driver + scoreboard: replay each queued cycle and compare.
  task automatic run_trace;
    cyc_t r;
    exp_t obs;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(negedge clk);
      rst            = r.rst;
      bif.i_MemReady = r.ready;
      bif.i_Zero     = r.zero;
      bif.i_Opcode   = r.op;
      #1;
      obs.state     = bif.o_State;
      obs.pcen      = bif.o_PCen;
      obs.iord      = bif.o_IorD;
      obs.pcsrc     = bif.o_PCsrc;
      obs.irwrite   = bif.o_IRwrite;
      obs.memread   = bif.o_MemRead;
      obs.memwrite  = bif.o_MemWrite;
      obs.regwrite  = bif.o_RegWrite;
      obs.resultsrc = bif.o_ResultSrc;
      obs.srca      = bif.o_ALUsrcA;
      obs.srcb      = bif.o_ALUsrcB;
      obs.aluop     = bif.o_ALUop;
      obs.illegal   = bif.o_Illegal;
      if (r.chk) begin
        tests++;
        assert (obs === r.e) else begin
          fails++;
          $error("FAIL cycle%0d state observed=%0d expected=%0d ctrl observed=%h expected=%h",
                 cyc_no, obs.state, r.e.state, obs, r.e);
        end
      end
      cyc_no++;
    end
  endtask

  task automatic push_reset(input int n);
    cyc_t r;
    for (int i = 0; i < n; i++) begin
      r = c(4'd0); r.rst = 1'b1; push(r);
    end
    r = c(4'd0); push(r);   // IDLE after release
  endtask

  initial begin
    cyc_t r;
    logic [6:0] ops [7];
    logic [6:0] op;
    bif.i_MemReady = 1'b0;
    bif.i_Zero     = 1'b0;
    bif.i_Opcode   = '0;
    ops = '{LW, SW_, RT, IT, BQ, JL, 7'b1111111};

    // Step 1: reset 3 cycles, IDLE, fetch with immediate ready, decode.
    push_reset(3);
    gen_instr(RT, 0, 0, 1'b0);
    run_trace();

    // Step 2: fetch waits 4 cycles.
    gen_instr(IT, 4, 0, 1'b0);
    run_trace();

    // Step 3: lw with 2 wait cycles; sw with immediate ready.
    gen_instr(LW, 0, 2, 1'b0);
    gen_instr(SW_, 0, 0, 1'b0);
    run_trace();

    // Step 4: beq taken / not taken, jal, illegal opcode.
    gen_instr(BQ, 0, 0, 1'b1);
    gen_instr(BQ, 0, 0, 1'b0);
    gen_instr(JL, 0, 0, 1'b0);
    gen_instr(7'b1111111, 0, 0, 1'b0);
    run_trace();

    // Step 5: reset arrives while a store waits for memory.
    cur_op = SW_;
    push_fetch(0);
    r = c(4'd2); r.e.srca = 2'b10; r.e.srcb = 2'b10; push(r);
    r = c(4'd3); r.e.srca = 2'b01; r.e.srcb = 2'b10; push(r);
    for (int i = 0; i < 3; i++) begin
      r = c(4'd6); r.e.memwrite = 1'b1; r.e.iord = 1'b1; r.ready = 1'b0;
      r.rst = (i == 2);
      push(r);
    end
    r = c(4'd0); push(r);
    gen_instr(LW, 1, 0, 1'b0);
    run_trace();

    // Step 6: random instruction stream with random latencies.
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == 7'b1111111 && $urandom_range(0, 1) == 1)
        op = 7'($urandom_range(0, 127));
      gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end
    run_trace();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control state machine for the multicycle datapath.
- Decodes the instruction-register opcode and sequences fetch, decode, execute, memory and writeback.
- Drives the PC/address stage selects: PC enable, instruction/data address select, PC source. Also drives IR/memory/register-file/ALU-mux controls.
- Supports a variable-latency memory through a ready handshake.

Parameters:
- OPW, 7, opcode field width.
- SW, 4, state/debug output width.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_Opcode  in  OPW  instr[6:0] from instruction register
- i_Zero  in  1  ALU zero flag, combinational, current cycle
- i_MemReady  in  1  memory completed the current read/write this cycle
- o_PCen  out  1  PC register load enable
- o_IorD  out  1  0 = PC drives address, 1 = ALUOut drives address
- o_PCsrc  out  2  00 = live ALU result, 01 = ALUOut register, 10 = immediate
- o_IRwrite  out  1  load IR and OldPC
- o_MemRead  out  1  memory read request
- o_MemWrite  out  1  memory write request
- o_RegWrite  out  1  register-file write
- o_ResultSrc  out  2  writeback: 00 ALUOut, 01 memory data reg, 10 PC
- o_ALUsrcA  out  2  00 PC, 01 regA, 10 OldPC
- o_ALUsrcB  out  2  00 regB, 01 constant 4, 10 immediate
- o_ALUop  out  2  00 add, 01 subtract, 10 funct-decoded
- o_State  out  SW  current state encoding (debug)
- o_Illegal  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- Moore FSM with one registered state. All outputs are combinational decode of state; the only input terms are i_MemReady and i_Zero, where noted.
- Any output not listed for a state is 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXER=7, EXEI=8, ALUWB=9, BEQ=10, JAL=11, ILL=12. Unused codes go to IDLE next cycle.
- Reset: state <= IDLE. In IDLE all outputs are 0, and o_State=0. IDLE -> FETCH unconditionally. Reset mid-instruction aborts with no further memory or register writes.
- FETCH:
  - o_MemRead=1, o_IorD=0, ALUsrcA=00, ALUsrcB=01, ALUop=00.
  - While i_MemReady=0: hold in FETCH with o_PCen=0, o_IRwrite=0.
  - When i_MemReady=1: o_IRwrite=1, o_PCen=1, PCsrc=00 (PC+4); next state DECODE.
- DECODE: ALUsrcA=10, ALUsrcB=10, ALUop=00 (branch/jump target into ALUOut). Next state by opcode:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXER
  - 0010011 -> EXEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - otherwise -> ILL
- MEMADR: ALUsrcA=01, ALUsrcB=10, ALUop=00. Next state MEMRD if lw, MEMWR if sw.
- MEMRD: o_MemRead=1, o_IorD=1. Hold until i_MemReady=1, then -> MEMWB.
- MEMWB: o_RegWrite=1, ResultSrc=01. Next FETCH.
- MEMWR: o_MemWrite=1, o_IorD=1. Hold until i_MemReady=1, then -> FETCH. o_MemWrite stays high for the whole wait.
- EXER: ALUsrcA=01, ALUsrcB=00, ALUop=10. Next ALUWB.
- EXEI: ALUsrcA=01, ALUsrcB=10, ALUop=10. Next ALUWB.
- ALUWB: o_RegWrite=1, ResultSrc=00. Next FETCH.
- BEQ: ALUsrcA=01, ALUsrcB=00, ALUop=01, PCsrc=01, o_PCen=i_Zero. Next FETCH.
- JAL: PCsrc=01, o_PCen=1, o_RegWrite=1, ResultSrc=10 (PC already holds PC+4). Next FETCH.
- ILL: o_Illegal=1 for exactly one cycle, no writes. Next FETCH.
- o_PCen is never asserted together with o_MemWrite.
- o_IorD=1 only in MEMRD and MEMWR.

Test Plan:
- Reset held 3 cycles, then released with i_MemReady=1: o_State sequence 0,1,2. All outputs 0 during reset and IDLE. o_PCen=1, o_IRwrite=1 in the FETCH cycle.
- Fetch with i_MemReady low for 4 cycles: FETCH held 5 cycles. o_PCen/o_IRwrite are 0 for 4 cycles, then 1 for one cycle.
- lw (0000011), memory ready after 2 wait cycles: states 1,2,3,4,4,4,5,1. o_IorD=1 only in state 4. o_RegWrite=1, ResultSrc=01 in state 5.
- sw (0100011), i_MemReady=1 immediately: states 1,2,3,6,1. o_MemWrite=1 for exactly one cycle, o_RegWrite never asserted.
- beq (1100011) with i_Zero=1, then repeated with i_Zero=0: o_PCen=1/0 respectively in state 10, PCsrc=01. jal (1101111): o_PCen=1, o_RegWrite=1, ResultSrc=10 in state 11.
- Opcode 1111111: states 1,2,12,1. o_Illegal high exactly one cycle. Reset asserted during MEMWR: next state 0, o_MemWrite=0 from the following cycle.
